mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter that shares one single-ported 64-word data memory between the instruction-fetch port and the load/store port of the MIPS core. Each cycle it grants at most one requester and drives the RAM's word address, write enable and write data. It registers the combinational RAM read data back to the winning port one cycle later. Data accesses have priority. A starvation counter guarantees forward progress for instruction fetch.

## Interface
Parameters:
- AW, 6, word-address width driven to the RAM (depth 2^AW words)
- DW, 32, data width
- STARVE_LIMIT, 3, consecutive denied fetch cycles after which fetch wins a conflict

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- i_req  in  1  fetch request; held until i_gnt
- i_addr  in  32  fetch byte address
- i_gnt  out  1  fetch granted this cycle (combinational)
- i_rvalid  out  1  i_rdata valid (registered)
- i_rdata  out  DW  fetched word
- d_req  in  1  load/store request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  load/store byte address
- d_wdata  in  DW  store data
- d_gnt  out  1  load/store granted this cycle (combinational)
- d_rvalid  out  1  d_rdata valid for a granted load (registered)
- d_rdata  out  DW  loaded word
- d_err  out  1  misaligned access flag (registered pulse)
- m_we  out  1  RAM write enable
- m_a  out  AW  RAM word address
- m_wd  out  DW  RAM write data
- m_rd  in  DW  RAM combinational read data

## Operation
- Word index for both ports is addr[AW+1:2]. Upper address bits are ignored, so addresses wrap modulo 2^AW words.
- Arbitration, evaluated every cycle while reset=0:
  - neither request: no grant; m_we=0.
  - one request: grant it.
  - both requests: grant fetch if starve_cnt==STARVE_LIMIT, otherwise grant data.
- At most one of i_gnt/d_gnt is high. Both are 0 while reset=1.
- m_a selects the granted port's word index. It holds the data-port index when there is no grant (don't-care).
- m_wd = d_wdata always.
- m_we = d_gnt & d_we & (d_addr[1:0]==0).
- Misaligned data access (d_addr[1:0]!=0):
  - still granted and consumes the slot;
  - no RAM write;
  - d_err=1 on the next cycle;
  - d_rvalid=0 for that access;
  - d_rdata unchanged.
- Fetch alignment is not checked: i_addr[1:0] is ignored.
- starve_cnt, width clog2(STARVE_LIMIT+1):
  - cleared when i_gnt=1 or i_req=0;
  - otherwise increments, saturating at STARVE_LIMIT.
- Read return, on the cycle after a grant:
  - granted fetch: i_rdata <= m_rd, i_rvalid=1.
  - granted aligned load: d_rdata <= m_rd, d_rvalid=1.
  - stores: no rvalid.
  - rdata registers hold their value when not loaded.
- Store followed immediately by a load to the same word returns the new data. The RAM write commits at the grant edge and the load reads after it.

## Timing
- Grant: same cycle as the request (0-cycle latency, combinational from req/addr/starve_cnt).
- Read data: 1 cycle after the grant edge. i_rvalid, d_rvalid and d_err are single-cycle pulses per grant.
- Throughput: one access per cycle total. Back-to-back grants to the same port are allowed.
- Reset, synchronous; after the first edge with reset=1:
  - i_rvalid=d_rvalid=d_err=0;
  - i_rdata=d_rdata=0;
  - starve_cnt=0.
- Reset mid-operation: a read granted on the cycle before reset produces no rvalid.
- Requesters must re-issue requests after reset.

## Test plan
- Reset: assert reset 2 cycles with both req=1 -> i_gnt=d_gnt=m_we=0; all registered outputs 0.
- Single fetch: i_req=1, i_addr=0x14 -> i_gnt same cycle, m_a=5; next cycle i_rvalid=1, i_rdata=RAM[5].
- Store then load:
  - store d_addr=0x20, d_wdata=0xDEADBEEF -> m_we=1, m_a=8;
  - next cycle load 0x20 -> d_rvalid=1, d_rdata=0xDEADBEEF the following cycle.
- Conflict and starvation, STARVE_LIMIT=3, both req held continuously:
  - grants D,D,D,I,D,D,D,I...;
  - starve_cnt clears on each I grant.
- Misaligned store d_addr=0x22 -> d_gnt=1, m_we=0, RAM unchanged; next cycle d_err=1, d_rvalid=0.
- Wrap: load d_addr=0x104 (word 65) -> m_a=1; returns RAM[1].

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Purpose : shares one single-ported RAM between instruction fetch and load/store.
// Latency : grant is combinational (0 cycles); read data returns 1 cycle after grant.
// Backpressure: the losing requester simply stays un-granted and must hold its request.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   i_req/i_addr          fetch request and byte address (low 2 bits ignored)
//   i_gnt                 fetch granted this cycle (combinational)
//   i_rvalid/i_rdata      registered fetch return, one cycle after i_gnt
//   d_req/d_we/d_addr/d_wdata  load/store request, direction, byte address, store data
//   d_gnt                 load/store granted this cycle (combinational)
//   d_rvalid/d_rdata      registered load return, one cycle after d_gnt on an aligned load
//   d_err                 registered pulse for a misaligned granted data access
//   m_we/m_a/m_wd/m_rd    RAM write enable, word address, write data, combinational read data
module mem_port_arbiter #(
  parameter int AW           = 6,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          i_req,
  input  logic [31:0]   i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,

  input  logic          d_req,
  input  logic          d_we,
  input  logic [31:0]   d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,

  output logic          m_we,
  output logic [AW-1:0] m_a,
  output logic [DW-1:0] m_wd,
  input  logic [DW-1:0] m_rd
);

  // Counter must be able to hold STARVE_LIMIT itself; guard the degenerate limit of 0.
  localparam int            SW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  // ------------------------------------------------------------------
  // Address decode
  // ------------------------------------------------------------------
  logic [AW-1:0] i_idx;
  logic [AW-1:0] d_idx;
  logic          d_misaligned;

  assign i_idx        = i_addr[AW+1:2];
  assign d_idx        = d_addr[AW+1:2];
  assign d_misaligned = |d_addr[1:0];

  // Upper address bits wrap away and fetch byte offset is ignored by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:AW+2], i_addr[1:0], d_addr[31:AW+2]};

  // ------------------------------------------------------------------
  // Arbitration
  // ------------------------------------------------------------------
  logic [SW-1:0] starve_cnt;
  logic          fetch_starved;
  logic          fetch_wins;

  always_comb begin
    fetch_starved = (starve_cnt == STARVE_MAX);
    // Data normally wins a conflict; fetch wins only once it has been
    // denied STARVE_LIMIT cycles in a row.
    fetch_wins    = i_req & (~d_req | fetch_starved);
    i_gnt         = ~reset & fetch_wins;
    d_gnt         = ~reset & d_req & ~fetch_wins;
  end

  // ------------------------------------------------------------------
  // RAM drive
  // ------------------------------------------------------------------
  always_comb begin
    m_a  = i_gnt ? i_idx : d_idx;
    m_wd = d_wdata;
    // A misaligned store still consumes the slot but must not touch memory.
    m_we = d_gnt & d_we & ~d_misaligned;
  end

  // ------------------------------------------------------------------
  // Starvation counter: counts consecutive cycles fetch asked and lost.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (i_gnt || !i_req) begin
      starve_cnt <= '0;
    end else if (!fetch_starved) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // ------------------------------------------------------------------
  // Read return path
  // ------------------------------------------------------------------
  logic d_load_ok;
  logic d_err_hit;
  logic i_rvalid_q;
  logic d_rvalid_q;
  logic d_err_q;

  assign d_load_ok = d_gnt & ~d_we & ~d_misaligned;
  assign d_err_hit = d_gnt & d_misaligned;

  always_ff @(posedge clk) begin
    if (reset) begin
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      d_err_q    <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      i_rvalid_q <= i_gnt;
      d_rvalid_q <= d_load_ok;
      d_err_q    <= d_err_hit;
      if (i_gnt) begin
        i_rdata <= m_rd;
      end
      if (d_load_ok) begin
        d_rdata <= m_rd;
      end
    end
  end

  // An access granted just before reset asserts must not report a response
  // during the reset cycle, so the strobes are masked by reset.
  assign i_rvalid = i_rvalid_q & ~reset;
  assign d_rvalid = d_rvalid_q & ~reset;
  assign d_err    = d_err_q & ~reset;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : randomized + directed scoreboard bench for mem_port_arbiter.
// Latency : expects grants same cycle, responses exactly one cycle later.
// Backpressure: requesters hold requests until the reference model grants them.
module tb_mem_port_arbiter;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int LIMIT = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req;
  logic [31:0]   i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [31:0]   d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          d_err;
  logic          m_we;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_wd;
  logic [DW-1:0] m_rd;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_we(m_we), .m_a(m_a), .m_wd(m_wd), .m_rd(m_rd)
  );

  // Environment RAM driven by the DUT.
  logic [DW-1:0] ram [DEPTH];
  assign m_rd = ram[m_a];
  always @(posedge clk) if (m_we) ram[m_a] <= m_wd;

  // Reference model state.
  logic [DW-1:0] refm [DEPTH];
  int            streak;       // consecutive cycles fetch asked and was refused
  bit            rst_prev;
  logic [DW-1:0] i_hold, d_hold;

  typedef struct {
    int            cyc;
    bit            err;
    logic [DW-1:0] data;
  } resp_t;
  resp_t iq[$];
  resp_t dq[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive at posedge+1, check and update model at negedge.
  task automatic cycle(input bit rst, input bit ir, input logic [31:0] ia,
                       input bit dr, input bit dw, input logic [31:0] da,
                       input logic [31:0] dd, output bit ig, output bit dg);
    logic [AW-1:0] widx;
    resp_t r;
    reset = rst; i_req = ir; i_addr = ia;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    @(negedge clk);
    ig = 1'b0; dg = 1'b0;
    if (rst) begin
      chk("rst_i_gnt", 32'(i_gnt), 0);
      chk("rst_d_gnt", 32'(d_gnt), 0);
      chk("rst_m_we", 32'(m_we), 0);
      chk("rst_i_rvalid", 32'(i_rvalid), 0);
      chk("rst_d_rvalid", 32'(d_rvalid), 0);
      chk("rst_d_err", 32'(d_err), 0);
      if (rst_prev) begin
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
      end
      iq.delete(); dq.delete();
      streak = 0; i_hold = '0; d_hold = '0;
      rst_prev = 1'b1;
    end else begin
      ig = ir && (!dr || streak == LIMIT);
      dg = dr && !ig;
      chk("i_gnt", 32'(i_gnt), 32'(ig));
      chk("d_gnt", 32'(d_gnt), 32'(dg));
      widx = ig ? ia[AW+1:2] : da[AW+1:2];
      if (ig || dg) chk("m_a", 32'(m_a), 32'(widx));
      chk("m_we", 32'(m_we), 32'(dg && dw && da[1:0] == 2'b00));
      if (dg && dw) chk("m_wd", m_wd, dd);
      r.cyc = cyc;
      if (ig) begin
        r.err = 1'b0; r.data = refm[widx]; iq.push_back(r);
      end
      if (dg) begin
        if (da[1:0] != 2'b00) begin
          r.err = 1'b1; r.data = '0; dq.push_back(r);
        end else if (!dw) begin
          r.err = 1'b0; r.data = refm[widx]; dq.push_back(r);
        end else begin
          refm[widx] = dd;
        end
      end
      if (ig || !ir) streak = 0;
      else if (streak < LIMIT) streak++;
      rst_prev = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops scoreboard entries when the DUT presents a response.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (i_rvalid) begin
          if (iq.size() == 0 || iq[0].cyc != cyc - 1) begin
            chk("i_rvalid_unexpected", 1, 0);
          end else begin
            chk("i_rdata", i_rdata, iq[0].data);
            i_hold = iq[0].data;
            void'(iq.pop_front());
          end
        end else begin
          chk("i_rdata_hold", i_rdata, i_hold);
        end
        while (iq.size() > 0 && iq[0].cyc <= cyc - 1) begin
          chk("i_resp_missing", 0, 1);
          void'(iq.pop_front());
        end

        if (d_rvalid || d_err) begin
          if (dq.size() == 0 || dq[0].cyc != cyc - 1) begin
            chk("d_resp_unexpected", 1, 0);
          end else begin
            chk("d_err", 32'(d_err), 32'(dq[0].err));
            chk("d_rvalid", 32'(d_rvalid), 32'(!dq[0].err));
            if (!dq[0].err) begin
              chk("d_rdata", d_rdata, dq[0].data);
              d_hold = dq[0].data;
            end else begin
              chk("d_rdata_err_hold", d_rdata, d_hold);
            end
            void'(dq.pop_front());
          end
        end else begin
          chk("d_rdata_hold", d_rdata, d_hold);
        end
        while (dq.size() > 0 && dq[0].cyc <= cyc - 1) begin
          chk("d_resp_missing", 0, 1);
          void'(dq.pop_front());
        end
      end
    end
  end

  initial begin
    bit ig, dg;
    bit ipend, dpend;
    logic [31:0] ia, da, dd;
    bit dw;
    string pat;

    for (int k = 0; k < DEPTH; k++) begin
      ram[k]  = $urandom;
      refm[k] = ram[k];
    end
    streak = 0; rst_prev = 1'b0; i_hold = '0; d_hold = '0;
    reset = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    @(posedge clk); #1;

    // Reset held two cycles with both requests high.
    cycle(1, 1, 32'h14, 1, 0, 32'h8, 0, ig, dg);
    cycle(1, 1, 32'h14, 1, 0, 32'h8, 0, ig, dg);

    // Single fetch of word 5.
    cycle(0, 1, 32'h14, 0, 0, 0, 0, ig, dg);
    // Store then immediate load of the same word.
    cycle(0, 0, 0, 1, 1, 32'h20, 32'hDEADBEEF, ig, dg);
    cycle(0, 0, 0, 1, 0, 32'h20, 0, ig, dg);
    cycle(0, 0, 0, 0, 0, 0, 0, ig, dg);

    // Continuous conflict: expected grant order D,D,D,I repeating.
    pat = "";
    for (int n = 0; n < 8; n++) begin
      cycle(0, 1, 32'h8 + 32'(n * 4), 1, 0, 32'h4, 0, ig, dg);
      pat = {pat, ig ? "I" : (dg ? "D" : "-")};
    end
    checks++;
    if (pat != "DDDIDDDI") begin
      fails++;
      $display("FAIL grant_pattern actual=%s required=DDDIDDDI", pat);
    end

    // Misaligned store: no write, error pulse; word 8 must keep 0xDEADBEEF.
    cycle(0, 0, 0, 1, 1, 32'h22, 32'h12345678, ig, dg);
    cycle(0, 0, 0, 1, 0, 32'h20, 0, ig, dg);
    // Misaligned load.
    cycle(0, 0, 0, 1, 0, 32'h3, 0, ig, dg);
    // Address wrap: byte 0x104 is word 65 -> word 1.
    cycle(0, 0, 0, 1, 0, 32'h104, 0, ig, dg);
    cycle(0, 0, 0, 0, 0, 0, 0, ig, dg);

    // Reset immediately after a granted fetch and load: no responses.
    cycle(0, 1, 32'h18, 0, 0, 0, 0, ig, dg);
    cycle(1, 0, 0, 0, 0, 0, 0, ig, dg);
    cycle(1, 0, 0, 0, 0, 0, 0, ig, dg);
    cycle(0, 0, 0, 1, 0, 32'h1C, 0, ig, dg);
    cycle(1, 0, 0, 0, 0, 0, 0, ig, dg);
    cycle(1, 0, 0, 0, 0, 0, 0, ig, dg);

    // Randomized traffic; requests are held until the model grants them.
    ipend = 1'b0; dpend = 1'b0; ia = '0; da = '0; dd = '0; dw = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!ipend && $urandom_range(0, 3) != 0) begin
        ipend = 1'b1;
        ia = {($urandom_range(0, 3) == 0) ? 22'($urandom) : 22'd0,
              4'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
      end
      if (!dpend && $urandom_range(0, 3) != 0) begin
        dpend = 1'b1;
        dw = 1'($urandom);
        da = {($urandom_range(0, 3) == 0) ? 22'($urandom) : 22'd0,
              4'd0, 4'($urandom_range(0, 15)),
              ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0};
        dd = $urandom;
      end
      cycle(0, ipend, ia, dpend, dw, da, dd, ig, dg);
      if (ig) ipend = 1'b0;
      if (dg) dpend = 1'b0;
    end

    // Drain and confirm nothing is left outstanding.
    for (int n = 0; n < 3; n++) cycle(0, 0, 0, 0, 0, 0, 0, ig, dg);
    chk("iq_drained", 32'(iq.size()), 0);
    chk("dq_drained", 32'(dq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
